// File: rtl/axis_fifo_pkg.sv
// rtl/axis_fifo_pkg.sv - shared types and constants for the AXI4-Stream packet FIFO
package axis_fifo_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_KEEP_WIDTH = DEF_DATA_WIDTH / 8;
   localparam int DEF_DEPTH      = 16;
   localparam int PTR_W          = $clog2(DEF_DEPTH) + 1;

   typedef struct packed {
      logic [DEF_KEEP_WIDTH-1:0] keep;
      logic                      last;
      logic [DEF_DATA_WIDTH-1:0] data;
   } axis_beat_t;

   typedef enum logic [1:0] {IDLE, SEND, FORCE} rd_state_e;

   // Pointer carries one extra wrap bit above the address
   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// rtl/axis_fifo_ram.sv - simple dual-port beat storage, synchronous write, asynchronous read
module axis_fifo_ram #(
   parameter  int WIDTH = 10,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             aclk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge aclk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axis_pkt_fifo.sv
// rtl/axis_pkt_fifo.sv - AXI4-Stream FIFO; define AXIS_PKT_FIFO_STORE_FWD_EN for store-and-forward
module axis_pkt_fifo
   import axis_fifo_pkg::*;
#(
   parameter  int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter  int DEPTH        = DEF_DEPTH,
   parameter  int AFULL_THRESH = DEPTH - 2,
   localparam int KEEP_WIDTH   = DATA_WIDTH / 8,
   localparam int PW           = ptr_width(DEPTH)
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic                  s_axis_tlast,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic                  m_axis_tlast,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic [PW-1:0]         occupancy,
   output logic                  almost_full
);

   localparam int AW = PW - 1;

   typedef struct packed {
      logic [KEEP_WIDTH-1:0] keep;
      logic                  last;
      logic [DATA_WIDTH-1:0] data;
   } beat_t;

   logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, occ_nxt;
   logic          full, empty, push, pop;
   beat_t         wr_beat, rd_beat;

   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign empty = (wr_ptr == rd_ptr);

   // Ready is held low for the whole reset cycle regardless of stale pointers
   assign s_axis_tready = !areset && !full;
   assign push          = s_axis_tvalid && s_axis_tready;
   assign pop           = m_axis_tvalid && m_axis_tready;

   assign wr_ptr_nxt = wr_ptr + PW'(push);
   assign rd_ptr_nxt = rd_ptr + PW'(pop);
   assign occ_nxt    = wr_ptr_nxt - rd_ptr_nxt;

   always_ff @(posedge aclk) begin
      if (areset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         occupancy   <= '0;
         almost_full <= 1'b0;
      end else begin
         wr_ptr      <= wr_ptr_nxt;
         rd_ptr      <= rd_ptr_nxt;
         occupancy   <= occ_nxt;
         almost_full <= (occ_nxt >= PW'(AFULL_THRESH));
      end
   end

   assign wr_beat = {s_axis_tkeep, s_axis_tlast, s_axis_tdata};

   axis_fifo_ram #(.WIDTH($bits(beat_t)), .DEPTH(DEPTH)) u_ram (
      .aclk    (aclk),
      .wr_en   (push),
      .wr_addr (wr_ptr[AW-1:0]),
      .wr_data (wr_beat),
      .rd_addr (rd_ptr[AW-1:0]),
      .rd_data (rd_beat)
   );

   assign m_axis_tdata = rd_beat.data;
   assign m_axis_tkeep = rd_beat.keep;
   assign m_axis_tlast = rd_beat.last;

`ifdef AXIS_PKT_FIFO_STORE_FWD_EN
   rd_state_e     state, state_nxt;
   logic [PW-1:0] pkt_cnt, pkt_cnt_nxt;
   logic          full_nxt;

   assign pkt_cnt_nxt = pkt_cnt + PW'(push && s_axis_tlast) - PW'(pop && rd_beat.last);
   assign full_nxt    = (occ_nxt == PW'(DEPTH));

   always_ff @(posedge aclk) begin
      if (areset) begin
         state   <= IDLE;
         pkt_cnt <= '0;
      end else begin
         state   <= state_nxt;
         pkt_cnt <= pkt_cnt_nxt;
      end
   end

   // Decisions use post-edge counts so a packet is released the cycle after its tlast lands
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (pkt_cnt_nxt != '0)  state_nxt = SEND;
            else if (full_nxt)      state_nxt = FORCE;
         end
         SEND: begin
            if (pop && rd_beat.last && (pkt_cnt_nxt == '0)) state_nxt = IDLE;
         end
         FORCE: begin
            if (pop && rd_beat.last) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      m_axis_tvalid = 1'b0;
      case (state)
         SEND, FORCE: m_axis_tvalid = !empty;
         default:     m_axis_tvalid = 1'b0;
      endcase
   end
`else
   assign m_axis_tvalid = !empty;
`endif

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// tb/tb_axis_pkt_fifo.sv - self-checking bench for axis_pkt_fifo against a queue-based model
module tb_axis_pkt_fifo;
   import axis_fifo_pkg::*;

   localparam int DW    = DEF_DATA_WIDTH;
   localparam int KW    = DW / 8;
   localparam int DEPTH = DEF_DEPTH;
   localparam int AFULL = DEPTH - 2;
   localparam int PW    = $clog2(DEPTH) + 1;
`ifdef AXIS_PKT_FIFO_STORE_FWD_EN
   localparam bit STORE_FWD = 1'b1;
`else
   localparam bit STORE_FWD = 1'b0;
`endif

   logic          aclk = 1'b0;
   logic          areset = 1'b1;
   logic [DW-1:0] s_tdata = '0;
   logic [KW-1:0] s_tkeep = '0;
   logic          s_tlast = 1'b0;
   logic          s_tvalid = 1'b0;
   logic          s_tready;
   logic [DW-1:0] m_tdata;
   logic [KW-1:0] m_tkeep;
   logic          m_tlast;
   logic          m_tvalid;
   logic          m_tready = 1'b0;
   logic [PW-1:0] occupancy;
   logic          almost_full;

   always #5 aclk = ~aclk;

   axis_pkt_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(AFULL)) dut (
      .aclk          (aclk),
      .areset        (areset),
      .s_axis_tdata  (s_tdata),
      .s_axis_tkeep  (s_tkeep),
      .s_axis_tlast  (s_tlast),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (s_tready),
      .m_axis_tdata  (m_tdata),
      .m_axis_tkeep  (m_tkeep),
      .m_axis_tlast  (m_tlast),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready),
      .occupancy     (occupancy),
      .almost_full   (almost_full)
   );

   // Model: FIFO contents as a queue; mode 0 = output gated, 1 = releasing packets, 2 = forced
   axis_beat_t    q[$];
   logic [DW-1:0] got[$];
   int            mode = 0;
   bit            started = 1'b0;
   bit            pushed = 1'b0;
   int            n_cmp = 0;
   int            n_bad = 0;
   int            max_occ = 0;

   function automatic int lasts_in_q();
      int n = 0;
      foreach (q[i]) if (q[i].last) n++;
      return n;
   endfunction

   function automatic bit mdl_tvalid();
      return (q.size() > 0) && (!STORE_FWD || mode != 0);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   initial forever begin : model
      axis_beat_t head;
      bit do_push, do_pop;
      int old_mode;
      @(posedge aclk);
      if (areset) begin
         q.delete();
         mode    = 0;
         started = 1'b1;
         pushed  = 1'b0;
      end else begin
         do_push  = s_tvalid && (q.size() < DEPTH);
         do_pop   = mdl_tvalid() && m_tready;
         head     = (q.size() > 0) ? q[0] : '0;
         old_mode = mode;
         pushed   = do_push;
         if (do_pop) begin
            void'(q.pop_front());
            got.push_back(head.data);
         end
         if (do_push) q.push_back(axis_beat_t'({s_tkeep, s_tlast, s_tdata}));
         if (STORE_FWD) begin
            if (do_pop && head.last && (old_mode == 2 || lasts_in_q() == 0)) mode = 0;
            if (old_mode == 0) begin
               if (lasts_in_q() > 0)      mode = 1;
               else if (q.size() == DEPTH) mode = 2;
            end
         end
      end
   end

   initial forever begin : compare
      bit ev;
      @(negedge aclk);
      if (started) begin
         ev = mdl_tvalid();
         chk("s_axis_tready", 32'(s_tready), 32'(!areset && q.size() < DEPTH));
         chk("m_axis_tvalid", 32'(m_tvalid), 32'(ev));
         chk("occupancy", 32'(occupancy), 32'(q.size()));
         chk("almost_full", 32'(almost_full), 32'(q.size() >= AFULL));
         if (ev) begin
            chk("m_axis_tdata", 32'(m_tdata), 32'(q[0].data));
            chk("m_axis_tkeep", 32'(m_tkeep), 32'(q[0].keep));
            chk("m_axis_tlast", 32'(m_tlast), 32'(q[0].last));
         end
      end
   end

   task automatic tick();
      @(posedge aclk);
      #2;
      if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
   endtask

   task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
      int n = 0;
      s_tvalid = 1'b1; s_tdata = d; s_tkeep = k; s_tlast = l;
      do begin
         tick();
         n++;
      end while (!pushed && n < 200);
      chk("send_accepted", 32'(pushed), 32'd1);
      s_tvalid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      m_tready = 1'b1;
      while (occupancy != '0 && n < 300) begin
         tick();
         n++;
      end
      chk("drain_empty", 32'(occupancy), 32'd0);
   endtask

   task automatic chk_got(input string name, input logic [DW-1:0] base, input int len);
      chk({name, "_count"}, 32'(got.size()), 32'(len));
      for (int i = 0; i < len && i < got.size(); i++)
         chk({name, "_data"}, 32'(got[i]), 32'(base + DW'(i)));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // Reset
      repeat (2) tick();
      chk("rst_tready_in_reset", 32'(s_tready), 32'd0);
      areset = 1'b0;
      #1;
      chk("rst_tready_after", 32'(s_tready), 32'd1);
      chk("rst_occupancy", 32'(occupancy), 32'd0);
      chk("rst_tvalid", 32'(m_tvalid), 32'd0);
      chk("rst_almost_full", 32'(almost_full), 32'd0);

      // 1: four beats, tlast on the fourth
      got.delete();
      m_tready = 1'b1;
      send(8'h11, 1'b1, 1'b0);
`ifndef AXIS_PKT_FIFO_STORE_FWD_EN
      chk("t1_cut_through_tvalid", 32'(m_tvalid), 32'd1);
      chk("t1_cut_through_tdata", 32'(m_tdata), 32'h11);
`endif
      send(8'h12, 1'b0, 1'b0);
      send(8'h13, 1'b1, 1'b0);
`ifdef AXIS_PKT_FIFO_STORE_FWD_EN
      chk("t1_sf_gated", 32'(m_tvalid), 32'd0);
`endif
      send(8'h14, 1'b1, 1'b1);
`ifdef AXIS_PKT_FIFO_STORE_FWD_EN
      chk("t1_sf_release", 32'(m_tvalid), 32'd1);
      chk("t1_sf_first", 32'(m_tdata), 32'h11);
`endif
      drain();
      chk_got("t1", 8'h11, 4);

      // 2: fill to DEPTH with the sink stalled
      m_tready = 1'b0;
      for (int k = 1; k <= DEPTH; k++) begin
         send(DW'(8'h20 + k), 1'b1, k == DEPTH);
         chk("t2_occupancy", 32'(occupancy), 32'(k));
         chk("t2_almost_full", 32'(almost_full), 32'(k >= 14));
      end
      chk("t2_full_tready", 32'(s_tready), 32'd0);
      m_tready = 1'b1;
      tick();
      m_tready = 1'b0;
      chk("t2_tready_after_pop", 32'(s_tready), 32'd1);
      chk("t2_occ_after_pop", 32'(occupancy), 32'd15);

      // 3: refill, then both sides active across the pointer wrap
      send(8'h40, 1'b1, 1'b0);
      chk("t3_full_occ", 32'(occupancy), 32'd16);
      m_tready = 1'b1;
      s_tvalid = 1'b1; s_tdata = DW'($urandom); s_tkeep = KW'($urandom); s_tlast = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (i < 2) chk("t3_occ_steady", 32'(occupancy), 32'd15);
         if (pushed) begin
            s_tdata = DW'($urandom);
            s_tkeep = KW'($urandom);
            s_tlast = 1'($urandom_range(0, 1));
         end
      end
      s_tvalid = 1'b0;
      send(8'h5F, 1'b1, 1'b1);
      drain();

`ifdef AXIS_PKT_FIFO_STORE_FWD_EN
      // 4: 5-beat packet with 2-cycle gaps is held until complete
      got.delete();
      m_tready = 1'b1;
      for (int b = 0; b < 5; b++) begin
         send(DW'(8'h70 + b), 1'b1, b == 4);
         if (b < 4) begin
            chk("t4_hold", 32'(m_tvalid), 32'd0);
            repeat (2) begin
               tick();
               chk("t4_hold_gap", 32'(m_tvalid), 32'd0);
            end
         end
      end
      for (int j = 0; j < 5; j++) begin
         chk("t4_burst_valid", 32'(m_tvalid), 32'd1);
         chk("t4_burst_data", 32'(m_tdata), 32'(8'h70 + j));
         tick();
      end
      chk("t4_after_burst", 32'(m_tvalid), 32'd0);
      chk_got("t4", 8'h70, 5);

      // 5: 20-beat packet forces cut-through once the FIFO fills
      got.delete();
      max_occ = 0;
      m_tready = 1'b1;
      for (int b = 0; b < 20; b++) send(DW'(b), 1'b1, b == 19);
      drain();
      chk("t5_peak_occ", 32'(max_occ), 32'd16);
      chk_got("t5", 8'h00, 20);
      chk("t5_idle_tvalid", 32'(m_tvalid), 32'd0);
`endif

      // 6: reset in the middle of a packet
      m_tready = 1'b0;
      for (int b = 0; b < 3; b++) send(DW'(8'h80 + b), 1'b1, 1'b0);
      areset = 1'b1;
      #1;
      chk("t6_tready_in_reset", 32'(s_tready), 32'd0);
      tick();
      areset = 1'b0;
      #1;
      chk("t6_occupancy", 32'(occupancy), 32'd0);
      chk("t6_tvalid", 32'(m_tvalid), 32'd0);
      chk("t6_tready", 32'(s_tready), 32'd1);
      got.delete();
      m_tready = 1'b1;
      for (int b = 0; b < 4; b++) send(DW'(8'h90 + b), 1'b1, b == 3);
      drain();
      chk_got("t6", 8'h90, 4);

      // Randomised traffic with back-pressure on both sides
      s_tvalid = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!s_tvalid || pushed) begin
            s_tvalid = ($urandom_range(0, 3) != 0);
            s_tdata  = DW'($urandom);
            s_tkeep  = KW'($urandom);
            s_tlast  = ($urandom_range(0, 3) == 0);
         end
         m_tready = ($urandom_range(0, 3) != 0);
         tick();
      end
      s_tvalid = 1'b0;
      send(8'hAA, 1'b1, 1'b1);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
